// File: rtl/int_ctrl.sv
// Programmable interrupt controller: latches, masks and prioritises NSRC requests onto one IRQ line.
// Optional macro INTC_SYNC_EN inserts a 2-flop synchroniser on every src bit.
module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] src,
    output logic            IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] prev_q;
    logic [3:0]      id_q, id_d;

    logic [NSRC-1:0] s;
    logic [1:0]      reg_sel;
    logic            wr_pend, wr_mask, wr_mode, ack;
    logic [3:0]      win;
    logic            any;
    logic            unused_bits;

    assign reg_sel     = Addr[3:2];
    assign unused_bits = ^{Addr[31:4], Din[31:NSRC]};

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = src;
`endif

    assign wr_pend = WE && (reg_sel == 2'd0);
    assign wr_mask = WE && (reg_sel == 2'd1);
    assign wr_mode = WE && (reg_sel == 2'd2);
    // A CAUSE write only counts as an acknowledge while a request is outstanding.
    assign ack     = WE && (reg_sel == 2'd3) && (state_q == S_REQ);

    // Lowest index wins: scanning downward leaves the lowest active bit last.
    always_comb begin
        win = 4'd0;
        any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_q[i] && mask_q[i]) begin
                win = 4'(i);
                any = 1'b1;
            end
        end
    end

    // Edge bits: a new rising edge beats a simultaneous W1C or ACK clear.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = (s[i] && !prev_q[i]) ||
                            (pend_q[i] && !((wr_pend && Din[i]) ||
                                            (ack && (id_q == 4'(i)))));
            end else begin
                pend_d[i] = s[i];
            end
        end
    end

    assign mask_d = wr_mask ? Din[NSRC-1:0] : mask_q;
    assign mode_d = wr_mode ? Din[NSRC-1:0] : mode_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (any) begin
                    id_d    = win;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            prev_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            prev_q  <= s;
            id_q    <= id_d;
        end
    end

    assign IRQ = (state_q == S_REQ);

    always_comb begin
        Dout = '0;
        case (reg_sel)
            2'd0: Dout[NSRC-1:0] = pend_q;
            2'd1: Dout[NSRC-1:0] = mask_q;
            2'd2: Dout[NSRC-1:0] = mode_q;
            default: begin
                Dout[31]  = (state_q == S_REQ);
                Dout[3:0] = id_q;
            end
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic against a bit-level reference model.
`timescale 1ns/100ps
module tb_int_ctrl;

    localparam int NSRC = 6;
`ifdef INTC_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [31:2]     Addr;
    logic            WE;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic [NSRC-1:0] src;
    logic            IRQ;

    int checks = 0;
    int errors = 0;

    int_ctrl #(.NSRC(NSRC)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .src  (src),
        .IRQ  (IRQ)
    );

    always #10 clk = ~clk;

    // Reference model state
    logic [NSRC-1:0] m_pend, m_mask, m_mode, m_prev, m_sy1, m_sy2;
    bit              m_busy, m_gap;
    int              m_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0;
        m_sy1  = '0; m_sy2  = '0; m_busy = 0;  m_gap  = 0; m_id = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[NSRC-1:0] = m_pend;
            2'd1: r[NSRC-1:0] = m_mask;
            2'd2: r[NSRC-1:0] = m_mode;
            default: begin
                r[31]  = m_busy;
                r[3:0] = 4'(m_id);
            end
        endcase
        return r;
    endfunction

    task automatic model_step(input logic [NSRC-1:0] sv, input logic we,
                              input logic [1:0] a, input logic [31:0] d);
        logic [NSRC-1:0] s, np;
        bit ack;
        int w;
        s   = SYNC ? m_sy2 : sv;
        ack = m_busy && we && (a == 2'd3);
        np  = m_pend;
        for (int i = 0; i < NSRC; i++) begin
            if (!m_mode[i])                                   np[i] = s[i];
            else if (s[i] && !m_prev[i])                      np[i] = 1'b1;
            else if ((we && a == 2'd0 && d[i]) || (ack && m_id == i)) np[i] = 1'b0;
        end
        w = -1;
        for (int i = 0; i < NSRC; i++)
            if (w < 0 && m_pend[i] && m_mask[i]) w = i;
        if (m_busy) begin
            if (ack) begin m_busy = 0; m_gap = 1; end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (w >= 0) begin
            m_busy = 1; m_id = w;
        end
        if (we && a == 2'd1) m_mask = d[NSRC-1:0];
        if (we && a == 2'd2) m_mode = d[NSRC-1:0];
        m_pend = np;
        m_prev = s;
        m_sy2  = m_sy1;
        m_sy1  = sv;
    endtask

    // One clock cycle: drive, compare against the model before the edge, advance the model.
    task automatic tick(input logic [NSRC-1:0] sv, input logic we,
                        input logic [1:0] a, input logic [31:0] d);
        src  = sv;
        WE   = we;
        Addr = {28'($urandom), a};
        Din  = d;
        #1;
        check("irq", 32'(IRQ), 32'(m_busy));
        check("dout", Dout, model_read(a));
        @(posedge clk);
        model_step(sv, we, a, d);
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [1:0] a, input logic [31:0] exp);
        WE   = 1'b0;
        Addr = {28'($urandom), a};
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic look_irq(input string tag, input logic exp);
        #1;
        check(tag, 32'(IRQ), 32'(exp));
    endtask

    task automatic do_reset();
        WE    = 1'b0;
        src   = NSRC'($urandom);
        reset = 1'b1;
        #1;
        check("rst_irq", 32'(IRQ), 32'd0);
        for (int a = 0; a < 4; a++) begin
            Addr = {28'($urandom), 2'(a)};
            #1;
            check("rst_dout", Dout, 32'd0);
        end
        model_clear();
        @(negedge clk);
        src = NSRC'($urandom);
        @(negedge clk);
        src   = '0;
        reset = 1'b0;
    endtask

    initial begin
        logic [NSRC-1:0] rs;
        logic [1:0]      ra;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        src   = '0;
        model_clear();
        @(negedge clk);
        do_reset();

`ifndef INTC_SYNC_EN
        // Edge source pulse, ACK clears it, IRQ stays low after the gap
        tick('0, 1, 2'd1, 32'h3F);
        tick('0, 1, 2'd2, 32'h01);
        tick(6'h01, 0, 2'd0, 0);
        look_irq("t2_irq_k", 1'b0);
        look("t2_pend_k", 2'd0, 32'h1);
        tick('0, 0, 2'd0, 0);
        look_irq("t2_irq", 1'b1);
        look("t2_cause", 2'd3, 32'h8000_0000);
        tick('0, 1, 2'd3, 0);
        look_irq("t2_ack_irq", 1'b0);
        look("t2_pend_ack", 2'd0, 32'h0);
        tick('0, 0, 2'd0, 0);
        tick('0, 0, 2'd0, 0);
        look_irq("t2_after_gap", 1'b0);

        // Two level sources: priority, gap, then the remaining one
        do_reset();
        tick('0, 1, 2'd1, 32'h3F);
        tick(6'h24, 0, 2'd0, 0);
        tick(6'h24, 0, 2'd0, 0);
        look("t3_cause2", 2'd3, 32'h8000_0002);
        tick(6'h20, 1, 2'd3, 0);
        look_irq("t3_gap", 1'b0);
        tick(6'h20, 0, 2'd0, 0);
        look("t3_idle", 2'd3, 32'h0000_0002);
        tick(6'h20, 0, 2'd0, 0);
        look("t3_cause5", 2'd3, 32'h8000_0005);

        // Masked edge stays pending; set beats W1C in the same cycle
        do_reset();
        tick('0, 1, 2'd2, 32'h02);
        tick(6'h02, 0, 2'd0, 0);
        tick('0, 0, 2'd0, 0);
        look("t4_pend", 2'd0, 32'h02);
        look_irq("t4_irq0", 1'b0);
        tick('0, 1, 2'd1, 32'h02);
        tick('0, 0, 2'd0, 0);
        look_irq("t4_irq1", 1'b1);
        tick(6'h02, 1, 2'd0, 32'h02);
        look("t4_setwins", 2'd0, 32'h02);

        // Mask dropped while in REQ: IRQ held until ACK
        do_reset();
        tick('0, 1, 2'd1, 32'h3F);
        tick(6'h08, 0, 2'd0, 0);
        tick(6'h08, 0, 2'd0, 0);
        tick(6'h08, 1, 2'd1, 32'h0);
        look_irq("t5_hold", 1'b1);
        look("t5_cause", 2'd3, 32'h8000_0003);
        tick(6'h08, 0, 2'd0, 0);
        tick(6'h08, 1, 2'd3, 0);
        look_irq("t5_ack", 1'b0);
        tick(6'h08, 0, 2'd0, 0);
        tick(6'h08, 0, 2'd0, 0);
        look_irq("t5_idle", 1'b0);
        look("t5_cause_idle", 2'd3, 32'h0000_0003);

        // Reset while IRQ is high
        tick(6'h08, 1, 2'd1, 32'h08);
        tick(6'h08, 0, 2'd0, 0);
        look_irq("t6_pre", 1'b1);
        do_reset();
`else
        // Synchronised source: IRQ rises on the fourth edge after the pulse edge
        tick('0, 1, 2'd1, 32'h3F);
        tick('0, 1, 2'd2, 32'h01);
        tick(6'h01, 0, 2'd0, 0);
        tick('0, 0, 2'd0, 0);
        tick('0, 0, 2'd0, 0);
        look_irq("t6s_pre", 1'b0);
        tick('0, 0, 2'd0, 0);
        look_irq("t6s_irq", 1'b1);
        do_reset();
`endif

        // Random traffic against the model, with periodic resets
        rs = '0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
                rs = '0;
            end
            for (int b = 0; b < NSRC; b++)
                if ($urandom_range(3) == 0) rs[b] = ~rs[b];
            ra = 2'($urandom);
            if ($urandom_range(2) == 0)
                tick(rs, 1'b1, ra, $urandom);
            else
                tick(rs, 1'b0, ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
